// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        RETRY,
        FAULT
    } pll_sup_state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int LOSS_CNT_W        = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop bit synchronizer into the refclk domain; both flops clear on reset.
module sync_2ff (
    input  logic refclk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset, qualifies the synchronized lock and releases the system
// reset only after a stable lock; bounded retries before latching a fault.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  restart,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  fault,
    output logic [RC_W-1:0]       retry_count,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RC_W-1:0]  RETRY_MAX   = RC_W'(MAX_RETRIES);

    pll_sup_state_e        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RC_W-1:0]       retry_q, retry_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  pll_rst_q, sys_rst_n_q, ready_q, fault_q;
    logic                  locked_s;

    sync_2ff u_lock_sync (
        .refclk (refclk),
        .rst_n  (rst_n),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            RESET_PLL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                cnt_d = cnt_q + 1'b1;
                // A lock seen on the timeout cycle still counts as a lock.
                if (locked_s)                   state_d = STABLE;
                else if (cnt_q == TIMEOUT_LAST) state_d = RETRY;
            end
            STABLE: begin
                cnt_d = cnt_q + 1'b1;
                if (!locked_s) begin
                    state_d = RETRY;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = RETRY;
                    if (loss_q != '1) loss_d = loss_q + 1'b1;
                end
            end
            RETRY: begin
                if (retry_q == RETRY_MAX) begin
                    state_d = FAULT;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = RESET_PLL;
                end
            end
            FAULT: begin
                if (restart) begin
                    retry_d = '0;
                    state_d = RESET_PLL;
                end
            end
            default: state_d = RESET_PLL;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            // Outputs decode the current state, so they trail transitions by a cycle.
            pll_rst_q   <= (state_q == RESET_PLL) || (state_q == FAULT);
            sys_rst_n_q <= (state_q == RUN);
            ready_q     <= (state_q == RUN);
            fault_q     <= (state_q == FAULT);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign loss_count  = loss_q;

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervisor on the far side of the PLL's `rst`/`locked` interface. Runs on the PLL reference clock, drives the PLL reset, and synchronizes and qualifies the asynchronous `locked` output. It releases the system reset only after a stable lock. On lock loss or lock timeout it re-resets the PLL a bounded number of times before latching a fault.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before a retry (≥2).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before RUN (≥1).
- `MAX_RETRIES`, 3: retries before FAULT (≥0).
- `refclk` in 1: 50 MHz reference clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `pll_locked` in 1: PLL lock indicator, asynchronous to `refclk`.
- `restart` in 1: single-cycle pulse; leaves FAULT only.
- `pll_rst` out 1: PLL reset, active-high.
- `sys_rst_n` out 1: downstream reset, active-low, `refclk` domain.
- `ready` out 1: high in RUN.
- `fault` out 1: high in FAULT.
- `retry_count` out $clog2(MAX_RETRIES+1): retries in the current bring-up.
- `loss_count` out 8: saturating count of lock losses while in RUN.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`. All decisions use `locked_s` only.
- One shared cycle counter `cnt`, cleared on every state entry.
- States:
  - RESET_PLL: `pll_rst`=1. When `cnt`==RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0. If `locked_s`, go to STABLE. Otherwise, when `cnt`==LOCK_TIMEOUT-1, go to RETRY.
  - STABLE: if `locked_s`=0, go to RETRY. When `cnt`==STABLE_CYCLES-1 with `locked_s`=1, go to RUN.
  - RUN: `sys_rst_n`=1 and `ready`=1. If `locked_s`=0, `loss_count`++ (saturates at 255) and go to RETRY.
  - RETRY: one cycle. If `retry_count`==MAX_RETRIES, go to FAULT. Otherwise `retry_count`++ and go to RESET_PLL.
  - FAULT: `pll_rst`=1, `fault`=1. On `restart`, clear `retry_count` and go to RESET_PLL.
- `retry_count` clears on entry to RUN. `loss_count` clears only on reset.
- `sys_rst_n`=0 in every state except RUN.
- `restart` outside FAULT is ignored.
- Counter width is $clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES. Comparisons are equality with no wrap. The counter never wraps because every terminal value forces a state exit.

## Timing
- Reset values (`rst_n`=0): state RESET_PLL, `cnt`=0, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fault`=0, `retry_count`=0, `loss_count`=0, synchronizer flops=0.
- Outputs are registered and decoded from the state register, so they change 1 cycle after the state transition edge.
- Lock-qualification latency: 2 cycles of synchronizer plus 1 cycle WAIT_LOCK→STABLE plus STABLE_CYCLES. `ready` rises STABLE_CYCLES+3 cycles after `pll_locked` is first sampled high.
- Lock loss in RUN: `sys_rst_n` falls 3 cycles after `pll_locked` falls.
- `rst_n` low mid-operation overrides everything within 1 cycle: back to reset values, and `pll_rst` reasserts.
- Lock glitch shorter than 1 cycle: may or may not be captured. If captured, it is treated as a real event.
- Simultaneous timeout and `locked_s` rise in WAIT_LOCK: `locked_s` wins (go to STABLE).
- Simultaneous `restart` and `rst_n`=0: reset wins.

## Structure
- Package `pll_sup_pkg` holds:
  - the state enum `pll_sup_state_e` (RESET_PLL, WAIT_LOCK, STABLE, RUN, RETRY, FAULT);
  - default parameter constants;
  - the `LOSS_CNT_W`=8 constant.
- Sub-module `sync_2ff`: a generic 2-flop bit synchronizer with the same `refclk`/`rst_n` interface. Its reset value is 0.
- The top module contains the FSM, the counter, and the statistics.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean bring-up:
  - release `rst_n` at cycle 0 → `pll_rst` high through cycle 4, then low.
  - raise `pll_locked` at cycle 10 → `ready`=1 and `sys_rst_n`=1 at cycle 21, with `retry_count`=0.
- Chatter in STABLE:
  - drop `pll_locked` for 3 cycles midway through STABLE → RETRY, `retry_count`=1, `pll_rst` pulses 4 cycles.
  - stable lock afterwards → RUN, and `retry_count` clears to 0.
- Lock never asserts → timeout and retry until FAULT:
  - 3 `pll_rst` pulses total;
  - `fault`=1, `pll_rst` held 1, `retry_count`=2.
- FAULT then `restart` pulse with `pll_locked`=1 → RESET_PLL, then RUN. `fault`=0.
- Lock loss in RUN:
  - drop `pll_locked` → `sys_rst_n`=0 and `ready`=0 after 3 cycles, `loss_count`=1;
  - full re-sequence follows.
  - Force 300 losses → `loss_count`=255.
- `rst_n` low for 1 cycle while in RUN → all outputs return to reset values, and the sequence restarts from RESET_PLL.
